// File: rtl/vram_host_arbiter.sv
// vram_host_arbiter
//   Shares the VRAM address/control bus between decoded ISA host memory
//   cycles (A0000-BFFFF) and the display line-buffer burst fetcher. The host
//   always wins at the next word boundary; a preempted burst resumes at its
//   saved word address once the host releases the bus.
//
// Ports
//   FPGACLK, RESET        clock, synchronous active-low reset
//   host_req/wr/addr      host cycle request (level), direction, byte address
//   host_sbhe_n           ISA SBHE, selects the high byte on even addresses
//   host_wdata            write data (steered onto the VRAM pads outside)
//   host_rdata/host_done  captured read data, one-cycle completion pulse
//   disp_req/addr/len     burst request (level), start word address, length
//   disp_data/valid/done  fetched word + qualifier, end-of-burst pulse
//   vram_*                word address, address-drive enable, strobes,
//                         byte enables, read data in, data-drive enable
module vram_host_arbiter #(
    parameter int ADDR_W     = 20,
    parameter int LEN_W      = 10,
    parameter int SETUP_CYC  = 1,
    parameter int ACCESS_CYC = 2
) (
    input  logic              FPGACLK,
    input  logic              RESET,
    input  logic              host_req,
    input  logic              host_wr,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic              host_sbhe_n,
    input  logic [15:0]       host_wdata,
    output logic [15:0]       host_rdata,
    output logic              host_done,
    input  logic              disp_req,
    input  logic [ADDR_W-2:0] disp_addr,
    input  logic [LEN_W-1:0]  disp_len,
    output logic [15:0]       disp_data,
    output logic              disp_valid,
    output logic              disp_done,
    output logic [ADDR_W-2:0] vram_addr,
    output logic              vram_addr_oe,
    output logic              vram_oe_n,
    output logic              vram_we_n,
    output logic              vram_lbe_n,
    output logic              vram_ube_n,
    input  logic [15:0]       vram_dq_in,
    output logic              vram_dq_oe
);

    typedef enum logic [2:0] {
        IDLE, D_READ, H_TURN, H_ACCESS, H_WAIT, D_TURN
    } state_t;

    localparam int CYC_W = 2;
    localparam logic [CYC_W-1:0] ACC_LAST = CYC_W'(ACCESS_CYC - 1);
    localparam logic [CYC_W-1:0] SET_LAST = CYC_W'(SETUP_CYC - 1);

    state_t              state, state_nxt;
    logic [CYC_W-1:0]    cyc;
    logic                gap;       // one-cycle oe_n-high spacer between burst words
    logic [ADDR_W-2:0]   addr;      // burst word address, survives host preemption
    logic [LEN_W-1:0]    cnt;       // words still to fetch
    logic                wr_q;      // host direction captured on entry to H_TURN
    logic                dq_tail;   // keeps the data drive one cycle past we_n rising

    // Write data goes to the pads at the top level; only its enable lives here.
    logic unused_wdata;
    assign unused_wdata = ^host_wdata;

    logic acc_last, set_last, word_end, host_end, last_word, disp_go;
    assign acc_last  = (cyc == ACC_LAST);
    assign set_last  = (cyc == SET_LAST);
    assign word_end  = (state == D_READ) && !gap && acc_last;
    assign host_end  = (state == H_ACCESS) && acc_last;
    assign last_word = (cnt == LEN_W'(1));
    // disp_done is high in the first IDLE cycle after a burst; the requester
    // only sees it then, so its still-high disp_req must not restart a burst.
    assign disp_go   = disp_req && !disp_done;

    // State register and datapath
    always_ff @(posedge FPGACLK) begin
        if (!RESET) begin
            state      <= IDLE;
            cyc        <= '0;
            gap        <= 1'b0;
            addr       <= '0;
            cnt        <= '0;
            wr_q       <= 1'b0;
            dq_tail    <= 1'b0;
            host_rdata <= '0;
            host_done  <= 1'b0;
            disp_data  <= '0;
            disp_valid <= 1'b0;
            disp_done  <= 1'b0;
        end else begin
            state <= state_nxt;

            if (state_nxt != state || (state == D_READ && (gap || acc_last)))
                cyc <= '0;
            else
                cyc <= cyc + CYC_W'(1);

            gap <= word_end && (state_nxt == D_READ);

            if (state == IDLE && state_nxt == D_READ) begin
                addr <= disp_addr;
                cnt  <= disp_len;
            end else if (word_end) begin
                addr <= addr + 1'b1;            // wraps over the word space
                cnt  <= cnt - LEN_W'(1);
            end

            if (state_nxt == H_TURN && state != H_TURN)
                wr_q <= host_wr;

            dq_tail   <= host_end && wr_q;
            host_done <= host_end;
            if (host_end && !wr_q)
                host_rdata <= vram_dq_in;

            disp_valid <= word_end;
            if (word_end)
                disp_data <= vram_dq_in;

            // The final word ends the burst even when the host preempts right
            // after it; otherwise the burst would restart from IDLE later.
            disp_done <= (word_end && last_word) ||
                         (state == IDLE && !host_req && disp_go && disp_len == '0);
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (host_req)
                    state_nxt = H_TURN;
                else if (disp_go && disp_len != '0)
                    state_nxt = D_READ;
            end
            D_READ: begin
                if (!gap && acc_last) begin
                    if (host_req)
                        state_nxt = H_TURN;
                    else if (last_word)
                        state_nxt = IDLE;
                end
            end
            H_TURN:   if (set_last) state_nxt = H_ACCESS;
            H_ACCESS: if (acc_last) state_nxt = H_WAIT;
            H_WAIT:   if (!host_req) state_nxt = D_TURN;
            D_TURN: begin
                if (set_last) begin
                    if (host_req)
                        state_nxt = H_TURN;
                    else if (cnt != '0 && disp_req)
                        state_nxt = D_READ;
                    else
                        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        vram_addr    = addr;
        vram_addr_oe = 1'b1;
        vram_oe_n    = 1'b1;
        vram_we_n    = 1'b1;
        vram_lbe_n   = 1'b1;
        vram_ube_n   = 1'b1;
        vram_dq_oe   = dq_tail;
        case (state)
            D_READ: begin
                if (!gap) begin
                    vram_oe_n  = 1'b0;
                    vram_lbe_n = 1'b0;
                    vram_ube_n = 1'b0;
                end
            end
            H_TURN, H_WAIT: begin
                vram_addr    = host_addr[ADDR_W-1:1];
                vram_addr_oe = 1'b0;
            end
            H_ACCESS: begin
                vram_addr    = host_addr[ADDR_W-1:1];
                vram_addr_oe = 1'b0;
                // Odd byte address selects the high byte only; SBHE adds the
                // high byte to an even access.
                vram_lbe_n   = host_addr[0];
                vram_ube_n   = ~host_addr[0] & host_sbhe_n;
                if (wr_q) begin
                    vram_we_n  = 1'b0;
                    vram_dq_oe = 1'b1;
                end else begin
                    vram_oe_n  = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_vram_host_arbiter.sv
module tb_vram_host_arbiter;

    localparam int ACCESS_CYC = 2;

    logic        FPGACLK;
    logic        RESET;
    logic        host_req, host_wr, host_sbhe_n;
    logic [19:0] host_addr;
    logic [15:0] host_wdata, host_rdata;
    logic        host_done;
    logic        disp_req;
    logic [18:0] disp_addr;
    logic [9:0]  disp_len;
    logic [15:0] disp_data;
    logic        disp_valid, disp_done;
    logic [18:0] vram_addr;
    logic        vram_addr_oe, vram_oe_n, vram_we_n, vram_lbe_n, vram_ube_n;
    logic [15:0] vram_dq_in;
    logic        vram_dq_oe;

    vram_host_arbiter #(.ADDR_W(20), .LEN_W(10), .SETUP_CYC(1), .ACCESS_CYC(ACCESS_CYC)) dut (
        .FPGACLK(FPGACLK), .RESET(RESET),
        .host_req(host_req), .host_wr(host_wr), .host_addr(host_addr),
        .host_sbhe_n(host_sbhe_n), .host_wdata(host_wdata),
        .host_rdata(host_rdata), .host_done(host_done),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_len(disp_len),
        .disp_data(disp_data), .disp_valid(disp_valid), .disp_done(disp_done),
        .vram_addr(vram_addr), .vram_addr_oe(vram_addr_oe),
        .vram_oe_n(vram_oe_n), .vram_we_n(vram_we_n),
        .vram_lbe_n(vram_lbe_n), .vram_ube_n(vram_ube_n),
        .vram_dq_in(vram_dq_in), .vram_dq_oe(vram_dq_oe)
    );

    initial FPGACLK = 1'b0;
    always #5 FPGACLK = ~FPGACLK;

    // VRAM model: contents derived from the word address unless overridden.
    logic        rd_force;
    logic [15:0] rd_val;
    always_comb vram_dq_in = rd_force ? rd_val : (vram_addr[15:0] ^ 16'hA5C3);

    typedef struct { logic [18:0] addr; logic [15:0] data; } dexp_t;
    typedef struct { logic wr; logic [18:0] addr; logic lbe_n; logic ube_n; logic [15:0] rdata; } hexp_t;
    dexp_t dq[$];
    hexp_t hq[$];

    int total = 0, bad = 0;
    int nvalid = 0, nhost = 0, ndone = 0, valid_at_host = 0;
    int d_low = 0, d_starts = 0, h_low = 0, h_starts = 0;
    logic [18:0] d_addr, h_addr;
    logic h_lbe, h_ube, h_we;
    logic prev_oe_n = 1'b1, prev_hlo = 1'b0, prev_aoe = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: sample at the falling edge, track bus activity, score outputs.
    task automatic tick();
        logic hlo;
        dexp_t de;
        hexp_t he;
        @(negedge FPGACLK);
        if (!vram_oe_n || !vram_we_n) begin
            chk("strobe_excl", 32'(!vram_oe_n && !vram_we_n), 32'd0);
            chk("aoe_stable", 32'(vram_addr_oe), 32'(prev_aoe));
        end
        if (!vram_oe_n && vram_addr_oe) begin
            if (prev_oe_n) begin d_low = 1; d_starts++; end
            else d_low++;
            d_addr = vram_addr;
        end
        hlo = !vram_addr_oe && (!vram_oe_n || !vram_we_n);
        if (hlo) begin
            if (!prev_hlo) begin h_low = 0; h_starts++; end
            h_low++;
            h_addr = vram_addr; h_lbe = vram_lbe_n; h_ube = vram_ube_n; h_we = !vram_we_n;
        end
        if (disp_valid) begin
            nvalid++;
            chk("disp_q_nonempty", 32'(dq.size() > 0), 32'd1);
            if (dq.size() > 0) begin
                de = dq.pop_front();
                chk("disp_addr", 32'(d_addr), 32'(de.addr));
                chk("disp_data", 32'(disp_data), 32'(de.data));
                chk("disp_oe_len", 32'(d_low), 32'(ACCESS_CYC));
            end
        end
        if (host_done) begin
            nhost++;
            valid_at_host = nvalid;
            chk("host_q_nonempty", 32'(hq.size() > 0), 32'd1);
            if (hq.size() > 0) begin
                he = hq.pop_front();
                chk("host_addr", 32'(h_addr), 32'(he.addr));
                chk("host_lbe", 32'(h_lbe), 32'(he.lbe_n));
                chk("host_ube", 32'(h_ube), 32'(he.ube_n));
                chk("host_dir", 32'(h_we), 32'(he.wr));
                chk("host_strobe_len", 32'(h_low), 32'(ACCESS_CYC));
                if (!he.wr) chk("host_rdata", 32'(host_rdata), 32'(he.rdata));
            end
        end
        if (disp_done) begin
            ndone++;
            disp_req = 1'b0;
        end
        prev_oe_n = vram_oe_n;
        prev_hlo  = hlo;
        prev_aoe  = vram_addr_oe;
    endtask

    function automatic int cur(input int which);
        case (which)
            0: return nvalid;
            1: return nhost;
            2: return ndone;
            default: return int'(!vram_oe_n && vram_addr_oe);
        endcase
    endfunction

    // Bounded wait: counter `which` reaches `target` within 300 cycles.
    task automatic wait_cnt(input string tag, input int which, input int target);
        int n = 0;
        while (cur(which) < target && n < 300) begin tick(); n++; end
        chk(tag, 32'(cur(which) >= target), 32'd1);
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_strobes"}, 32'({vram_oe_n, vram_we_n, vram_lbe_n, vram_ube_n}), 32'hF);
        chk({p, "_addr_oe"}, 32'(vram_addr_oe), 32'd1);
        chk({p, "_dq_oe"}, 32'(vram_dq_oe), 32'd0);
        chk({p, "_vaddr"}, 32'(vram_addr), 32'd0);
        chk({p, "_rdata"}, 32'(host_rdata), 32'd0);
        chk({p, "_ddata"}, 32'(disp_data), 32'd0);
        chk({p, "_pulses"}, 32'({host_done, disp_valid, disp_done}), 32'd0);
    endtask

    task automatic push_burst(input logic [18:0] start, input int len);
        dexp_t e;
        for (int i = 0; i < len; i++) begin
            e.addr = start + 19'(i);
            e.data = e.addr[15:0] ^ 16'hA5C3;
            dq.push_back(e);
        end
    endtask

    task automatic push_host(input logic wr, input logic [18:0] a, input logic l, input logic u, input logic [15:0] d);
        hexp_t e;
        e.wr = wr; e.addr = a; e.lbe_n = l; e.ube_n = u; e.rdata = d;
        hq.push_back(e);
    endtask

    int base;

    initial begin
        RESET = 1'b0; host_req = 1'b0; host_wr = 1'b0; host_addr = '0; host_sbhe_n = 1'b1;
        host_wdata = '0; disp_req = 1'b0; disp_addr = '0; disp_len = '0;
        rd_force = 1'b0; rd_val = '0;

        // Reset and quiet idle
        repeat (3) tick();
        chk_reset("rst");
        RESET = 1'b1;
        repeat (4) tick();
        chk("idle_pulses", 32'(nvalid + nhost + ndone), 32'd0);
        chk("idle_addr_oe", 32'(vram_addr_oe), 32'd1);

        // Zero-length burst: done only, no access
        disp_addr = 19'h00010; disp_len = 10'd0; disp_req = 1'b1;
        wait_cnt("len0_done", 2, 1);
        repeat (3) tick();
        chk("len0_done_cnt", 32'(ndone), 32'd1);
        chk("len0_no_valid", 32'(nvalid), 32'd0);
        chk("len0_no_strobe", 32'(d_starts), 32'd0);

        // Four-word burst across the top of the word space
        push_burst(19'h7FFFE, 4);
        disp_addr = 19'h7FFFE; disp_len = 10'd4; disp_req = 1'b1;
        wait_cnt("b1_done", 2, 2);
        chk("b1_valid_cnt", 32'(nvalid), 32'd4);
        chk("b1_q_empty", 32'(dq.size()), 32'd0);

        // Host write, odd address: high byte only, 1 turnaround + 2 access cycles
        host_addr = 20'hA0001; host_sbhe_n = 1'b1; host_wdata = 16'h12AB; host_wr = 1'b1;
        push_host(1'b1, 19'h50000, 1'b1, 1'b0, 16'h0);
        host_req = 1'b1;
        tick();
        chk("hw_turn_aoe", 32'(vram_addr_oe), 32'd0);
        chk("hw_turn_we", 32'(vram_we_n), 32'd1);
        chk("hw_turn_addr", 32'(vram_addr), 32'h50000);
        tick();
        chk("hw_we_low0", 32'(vram_we_n), 32'd0);
        chk("hw_dq_oe", 32'(vram_dq_oe), 32'd1);
        tick();
        chk("hw_we_low1", 32'(vram_we_n), 32'd0);
        tick();
        chk("hw_we_rise", 32'(vram_we_n), 32'd1);
        chk("hw_dq_tail", 32'(vram_dq_oe), 32'd1);
        chk("hw_done", 32'(host_done), 32'd1);
        tick();
        chk("hw_dq_off", 32'(vram_dq_oe), 32'd0);
        chk("hw_done_low", 32'(host_done), 32'd0);
        repeat (4) tick();
        chk("hw_no_repeat", 32'(h_starts), 32'd1);
        chk("hw_done_once", 32'(nhost), 32'd1);
        host_req = 1'b0;
        repeat (3) tick();
        chk("hw_release_aoe", 32'(vram_addr_oe), 32'd1);

        // Host read, even address with SBHE: both bytes
        rd_force = 1'b1; rd_val = 16'hBEEF;
        host_addr = 20'hB0000; host_sbhe_n = 1'b0; host_wr = 1'b0;
        push_host(1'b0, 19'h58000, 1'b0, 1'b0, 16'hBEEF);
        host_req = 1'b1;
        wait_cnt("hr_done", 1, 2);
        host_req = 1'b0; rd_force = 1'b0;
        repeat (4) tick();
        chk("hr_hold", 32'(host_rdata), 32'hBEEF);
        chk("hr_once", 32'(h_starts), 32'd2);

        // Host preempts an 8-word burst during word 2
        base = nvalid;
        push_burst(19'h00100, 8);
        disp_addr = 19'h00100; disp_len = 10'd8; disp_req = 1'b1;
        wait_cnt("mb_w1", 0, base + 1);
        wait_cnt("mb_w2_start", 3, 1);
        host_addr = 20'hA0010; host_sbhe_n = 1'b0; host_wr = 1'b0;
        push_host(1'b0, 19'h50008, 1'b0, 1'b0, 16'h0008 ^ 16'hA5C3);
        host_req = 1'b1;
        wait_cnt("mb_host", 1, 3);
        host_req = 1'b0;
        wait_cnt("mb_done", 2, 3);
        chk("mb_valid_total", 32'(nvalid - base), 32'd8);
        chk("mb_host_slot", 32'(valid_at_host - base), 32'd2);
        chk("mb_q_empty", 32'(dq.size()), 32'd0);

        // Simultaneous requests, then reset in the middle of the burst
        base = nvalid;
        host_addr = 20'hA0100; host_sbhe_n = 1'b0; host_wr = 1'b1;
        push_host(1'b1, 19'h50080, 1'b0, 1'b0, 16'h0);
        push_burst(19'h00200, 1);
        disp_addr = 19'h00200; disp_len = 10'd3;
        host_req = 1'b1; disp_req = 1'b1;
        wait_cnt("sr_host", 1, 4);
        chk("sr_host_first", 32'(valid_at_host - base), 32'd0);
        host_req = 1'b0;
        wait_cnt("sr_w1", 0, base + 1);
        wait_cnt("sr_w2_start", 3, 1);
        RESET = 1'b0;
        tick();
        chk_reset("mid_rst");
        RESET = 1'b1;
        push_burst(19'h00200, 3);
        wait_cnt("sr_done", 2, 4);
        chk("sr_valid_total", 32'(nvalid - base), 32'd4);
        chk("sr_q_empty", 32'(dq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
